// File: rtl/instr_fetch.sv
// Instruction-fetch front end: PC-driven ROM reads into a small prefetch queue
// with a valid/ready decode handshake and redirect flush. Optional FETCH_PERF_EN adds a stall counter.
module instr_fetch #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 2,
    parameter int RESET_PC = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       run,
    output logic [ADDR_W-1:0]          rom_addr,
    output logic                       rom_en,
    input  logic [DATA_W-1:0]          rom_data,
    input  logic                       redirect_valid,
    input  logic [ADDR_W-1:0]          redirect_addr,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [DATA_W-1:0]          instr,
    output logic [ADDR_W-1:0]          instr_pc,
    output logic [$clog2(DEPTH+1)-1:0] q_count
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]                stall_cycles
`endif
);

    localparam int          CW = $clog2(DEPTH + 1);
    localparam int unsigned DU = DEPTH;

    logic [ADDR_W-1:0] pc;
    logic [CW-1:0]     count;
    logic [CW-1:0]     wr_idx;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [ADDR_W-1:0] tag_q  [DEPTH];
    logic              full;
    logic              pop;
    logic              fetch;

    always_comb begin
        full   = (count == CW'(DEPTH));
        pop    = (count != '0) & instr_ready;
        fetch  = run & ~rst & ~redirect_valid & (~full | pop);
        // Tail slot as seen after this cycle's pop has shifted the queue down
        wr_idx = count - CW'(pop);
    end

    always_comb begin
        rom_addr    = pc;
        rom_en      = fetch;
        instr_valid = (count != '0);
        q_count     = count;
        instr       = '0;
        instr_pc    = '0;
        if (count != '0) begin
            instr    = data_q[0];
            instr_pc = tag_q[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= ADDR_W'(RESET_PC);
            count <= '0;
        end else if (redirect_valid) begin
            pc    <= redirect_addr;
            count <= '0;
        end else begin
            if (fetch) pc <= pc + 1'b1;
            count <= count + CW'(fetch) - CW'(pop);
        end
    end

    // Head always lives in slot 0; entries shift down on pop, push lands behind them
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DU; i++) begin
            if (fetch && wr_idx == CW'(i)) begin
                data_q[i] <= rom_data;
                tag_q[i]  <= pc;
            end else if (pop && (i + 1 < DU)) begin
                data_q[i] <= data_q[(i + 1) % DU];
                tag_q[i]  <= tag_q[(i + 1) % DU];
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (run && full && !pop && !redirect_valid && stall_cycles != 16'hFFFF) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed test-plan phases followed by random run/ready/redirect/reset.
module tb_instr_fetch;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [3:0]  rom_addr;
    logic        rom_en;
    logic [31:0] rom_data;
    logic        redirect_valid = 1'b0;
    logic [3:0]  redirect_addr = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [3:0]  instr_pc;
    logic [1:0]  q_count;
`ifdef FETCH_PERF_EN
    logic [15:0] stall_cycles;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0]  a;
        logic [31:0] d;
    } entry_t;

    entry_t     sb_q[$];
    logic [3:0] m_pc      = '0;
    bit         armed     = 0;
    bit         exp_fetch = 0;
    bit         exp_stall = 0;
    int         m_stall   = 0;

    always #5 clk = ~clk;

    // ROM: word k holds 0x1000 + k
    assign rom_data = 32'h1000 + 32'(rom_addr);

    instr_fetch #(
        .ADDR_W  (4),
        .DATA_W  (32),
        .DEPTH   (DEPTH),
        .RESET_PC(0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .rom_addr      (rom_addr),
        .rom_en        (rom_en),
        .rom_data      (rom_data),
        .redirect_valid(redirect_valid),
        .redirect_addr (redirect_addr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .q_count       (q_count)
`ifdef FETCH_PERF_EN
        ,
        .stall_cycles  (stall_cycles)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue contents advance on the clock edge
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_pc = '0;
                sb_q.delete();
                m_stall = 0;
                armed = 1;
            end else if (redirect_valid) begin
                m_pc = redirect_addr;
                sb_q.delete();
            end else begin
                if (exp_stall && m_stall < 16'hFFFF) m_stall++;
                if (exp_fetch) begin
                    sb_q.push_back('{a: m_pc, d: 32'h1000 + 32'(m_pc)});
                    m_pc = m_pc + 4'd1;
                end
            end
        end
    end

    // Monitor: compares mid-cycle, pops the scoreboard on an accepted handshake
    initial begin
        int  cnt;
        bit  pop;
        forever begin
            @(negedge clk);
            if (armed) begin
                cnt       = sb_q.size();
                pop       = (cnt > 0) && instr_ready;
                exp_fetch = run && !rst && !redirect_valid && (cnt < DEPTH || pop);
                exp_stall = run && !rst && !redirect_valid && (cnt == DEPTH) && !pop;
                check("rom_en",      32'(rom_en),      32'(exp_fetch));
                check("rom_addr",    32'(rom_addr),    32'(m_pc));
                check("q_count",     32'(q_count),     32'(cnt));
                check("instr_valid", 32'(instr_valid), 32'(cnt > 0));
                if (cnt > 0) begin
                    check("instr",    instr,          sb_q[0].d);
                    check("instr_pc", 32'(instr_pc),  32'(sb_q[0].a));
                end else begin
                    check("instr_empty",    instr,         32'h0);
                    check("instr_pc_empty", 32'(instr_pc), 32'h0);
                end
`ifdef FETCH_PERF_EN
                check("stall_cycles", 32'(stall_cycles), 32'(m_stall));
`endif
                if (pop) void'(sb_q.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic reset_pulse();
        rst = 1'b1; run = 1'b0; redirect_valid = 1'b0;
        step(1);
        rst = 1'b0;
    endtask

    initial begin
        // Stream from reset, continuing past the wrap at 15
        rst = 1'b1;
        step(2);
        rst = 1'b0; run = 1'b1; instr_ready = 1'b1;
        step(20);

        // Backpressure from the start
        reset_pulse();
        run = 1'b1; instr_ready = 1'b0;
        step(4);
        @(negedge clk);
        check("bp_q_count", 32'(q_count), 32'd2);
        check("bp_rom_en",  32'(rom_en),  32'd0);
        check("bp_instr",   instr,        32'h1000);
        step(1);
        instr_ready = 1'b1;
        step(6);

        // Redirect while full
        reset_pulse();
        run = 1'b1; instr_ready = 1'b0;
        step(2);
        redirect_valid = 1'b1; redirect_addr = 4'd9;
        step(1);
        redirect_valid = 1'b0;
        @(negedge clk);
        check("rd_q_count",     32'(q_count),     32'd0);
        check("rd_instr_valid", 32'(instr_valid), 32'd0);
        check("rd_rom_addr",    32'(rom_addr),    32'd9);
        step(1);
        @(negedge clk);
        check("rd_instr_pc", 32'(instr_pc), 32'd9);
        check("rd_instr",    instr,         32'h1009);
        step(1);
        instr_ready = 1'b1;
        step(3);

        // run pause at pc=5
        reset_pulse();
        run = 1'b1; instr_ready = 1'b1;
        step(5);
        run = 1'b0;
        @(negedge clk);
        check("pause_rom_en",   32'(rom_en),   32'd0);
        check("pause_rom_addr", 32'(rom_addr), 32'd5);
        step(3);
        run = 1'b1;
        step(1);
        @(negedge clk);
        check("resume_instr_pc", 32'(instr_pc), 32'd5);
        step(3);

        // Reset mid-operation with the queue full at pc=7
        reset_pulse();
        run = 1'b1; instr_ready = 1'b1;
        step(6);
        instr_ready = 1'b0;
        step(1);
        @(negedge clk);
        check("pre_rst_q_count",  32'(q_count),  32'd2);
        check("pre_rst_rom_addr", 32'(rom_addr), 32'd7);
        step(1);
        rst = 1'b1;
        step(1);
        @(negedge clk);
        check("rst_q_count",     32'(q_count),     32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_rom_addr",    32'(rom_addr),    32'd0);
        check("rst_rom_en",      32'(rom_en),      32'd0);
        step(1);
        rst = 1'b0; instr_ready = 1'b1;
        step(5);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            run            = ($urandom_range(99) < 80);
            instr_ready    = ($urandom_range(99) < 65);
            redirect_valid = ($urandom_range(99) < 8);
            redirect_addr  = 4'($urandom_range(15));
            rst            = ($urandom_range(99) < 2);
            step(1);
        end
        rst = 1'b0; redirect_valid = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
